serial_addsub: RTL and testbench
================================

// Module: serial_addsub
// PURPOSE
//  Bit-serial adder/subtractor: one full-adder cell plus a carry register, one bit per clock, LSB first.
//  Trades WIDTH cycles of latency for a single adder cell.
//  Sits beside the combinational adders as the area-optimised arithmetic unit.
//  Subtraction is a + ~b + 1: operand b is inverted and carry-in is preset to 1.
// PARAMETERS
//  WIDTH   8   operand/result width in bits (>= 2)
// PORTS
//  clk        in   1      single clock, rising edge
//  rst_n      in   1      asynchronous active-low reset
//  start      in   1      request; accepted only when ready=1
//  sub        in   1      0: a+b, 1: a-b; sampled with start
//  a          in   WIDTH  operand A, sampled with start
//  b          in   WIDTH  operand B, sampled with start
//  ready      out  1      1 in IDLE/DONE; start accepted in the same cycle
//  busy       out  1      1 while in RUN
//  done       out  1      one-cycle pulse; result/carry_out valid from this cycle
//  result     out  WIDTH  sum/difference, held until next accepted start
//  carry_out  out  1      add: carry out of MSB; sub: 1 = no borrow (a >= b unsigned)
// BEHAVIOUR
//  - Reset (async, rst_n=0): state=IDLE; ready=1, busy=0, done=0, result=0, carry_out=0; all internal regs cleared.
//  - FSM IDLE -> RUN on start&ready. RUN -> DONE after WIDTH bit-cycles. DONE -> IDLE after 1 cycle.
//  - Accept (start&ready):
//    - latch A_sh=a, B_sh=(sub ? ~b : b), carry=sub, cnt=0;
//    - clear result and carry_out;
//    - sub is captured here only; later changes are ignored.
//  - RUN, each cycle:
//    - s = A_sh[0]^B_sh[0]^carry;
//    - carry <= majority(A_sh[0],B_sh[0],carry);
//    - result <= {s, result[WIDTH-1:1]};
//    - A_sh, B_sh shift right by 1;
//    - cnt++.
//  - Leaving RUN: after cycle with cnt==WIDTH-1, carry_out <= final carry, go DONE.
//  - Latency: start accepted at edge N -> done=1 in cycle after edge N+WIDTH+1 (WIDTH+1 edges).
//  - done high exactly 1 cycle (DONE state). ready=1 in DONE, so back-to-back start in DONE is accepted.
//    This skips IDLE and clears result/carry_out next edge.
//  - start while busy: ignored, no effect on operation in flight.
//  - start held high continuously: new op accepted each time ready=1.
//  - Reset mid-RUN: immediate abort to reset values; no done pulse.
//  - Arithmetic is modulo 2^WIDTH; no saturation.
//  - Intermediate result bits are visible during RUN; valid only from done onward.
// CONFIGURATION
//  OVERFLOW_FLAG_EN defined:
//    - adds output port overflow (out, 1): signed two's-complement overflow;
//    - overflow = carry into MSB XOR carry out of MSB, captured on last RUN cycle;
//    - updates with carry_out, cleared on accept and reset, held like result.
//  OVERFLOW_FLAG_EN undefined: port absent, no related logic.
// TESTING (WIDTH=8)
//  1. add 8'h0F+8'h01 -> result 8'h10, carry_out 0, done exactly 9 edges after accept.
//  2. add 8'hFF+8'h01 -> result 8'h00, carry_out 1; sub 8'h07-8'h05 -> 8'h02, carry_out 1.
//  3. sub 8'h05-8'h07 -> result 8'hFE, carry_out 0 (borrow); with OVERFLOW_FLAG_EN: 8'h7F+8'h01 -> 8'h80, overflow 1.
//  4. start with a=8'h11,b=8'h22 pulsed again mid-RUN with a=8'hFF -> ignored; result 8'h33, single done pulse.
//  5. rst_n low at RUN cycle 4 -> all outputs at reset values, no done; next op 8'h01+8'h01 -> 8'h02.
//  6. start held high: ops 8'h10+8'h20 then 8'h03-8'h01 back-to-back from DONE -> results 8'h30 then 8'h02, two done pulses.

Source files
------------

// File: rtl/serial_addsub.sv
// serial_addsub: bit-serial adder/subtractor, one full-adder cell, LSB first.
// Optional OVERFLOW_FLAG_EN adds a signed two's-complement overflow output.
module serial_addsub #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             sub,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             ready,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             carry_out
`ifdef OVERFLOW_FLAG_EN
    ,
    output logic             overflow
`endif
);

    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t         state, state_nx;
    logic [WIDTH-1:0] a_sh, b_sh;
    logic [CW-1:0]  cnt;
    logic           carry, accept, step, s, c_nx;
`ifdef OVERFLOW_FLAG_EN
    logic           cin_msb;
`endif

    // Status decode, full-adder cell and next state; RUN ends with one finishing cycle after the MSB.
    always_comb begin
        ready    = state != RUN;
        busy     = state == RUN;
        done     = state == DONE;
        accept   = start && ready;
        step     = busy && (cnt != CW'(WIDTH));
        s        = a_sh[0] ^ b_sh[0] ^ carry;
        c_nx     = (a_sh[0] & b_sh[0]) | (carry & (a_sh[0] ^ b_sh[0]));
        state_nx = accept ? RUN : step ? RUN : busy ? DONE : IDLE;
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    // Operand capture, bit-serial shifting and final flag capture.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_sh      <= '0;
            b_sh      <= '0;
            cnt       <= '0;
            carry     <= 1'b0;
            result    <= '0;
            carry_out <= 1'b0;
`ifdef OVERFLOW_FLAG_EN
            cin_msb   <= 1'b0;
            overflow  <= 1'b0;
`endif
        end else if (accept) begin
            a_sh      <= a;
            b_sh      <= sub ? ~b : b;
            cnt       <= '0;
            carry     <= sub;
            result    <= '0;
            carry_out <= 1'b0;
`ifdef OVERFLOW_FLAG_EN
            overflow  <= 1'b0;
`endif
        end else if (step) begin
            a_sh   <= a_sh >> 1;
            b_sh   <= b_sh >> 1;
            carry  <= c_nx;
            result <= {s, result[WIDTH-1:1]};
            cnt    <= cnt + 1'b1;
`ifdef OVERFLOW_FLAG_EN
            if (cnt == CW'(WIDTH - 1)) cin_msb <= carry;
`endif
        end else if (busy) begin
            carry_out <= carry;
`ifdef OVERFLOW_FLAG_EN
            overflow  <= cin_msb ^ carry;
`endif
        end
    end

endmodule

// File: tb/tb_serial_addsub.sv
// tb_serial_addsub: directed and randomized checks of serial_addsub against an arithmetic model.
module tb_serial_addsub;

    localparam int W = 8;

    logic         clk = 1'b0, rst_n = 1'b0, start = 1'b0, sub = 1'b0;
    logic [W-1:0] a = '0, b = '0;
    logic         ready, busy, done, carry_out;
    logic [W-1:0] result;
`ifdef OVERFLOW_FLAG_EN
    logic         overflow;
`endif

    int checks = 0, errors = 0;

    serial_addsub #(.WIDTH(W)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .sub(sub), .a(a), .b(b),
        .ready(ready), .busy(busy), .done(done), .result(result), .carry_out(carry_out)
`ifdef OVERFLOW_FLAG_EN
        , .overflow(overflow)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: n counts cycles since the accepting edge (-1 when idle); outputs follow from n.
    int           n = -1;
    logic [W-1:0] m_res = '0, h_res = '0;
    logic         m_co = 1'b0, h_co = 1'b0, m_ov = 1'b0, h_ov = 1'b0;

    always @(negedge clk) begin : cmp
        logic         run;
        logic [W:0]   t;
        if (!rst_n) begin
            n = -1; h_res = '0; h_co = 1'b0; h_ov = 1'b0;
        end
        run = (n >= 0) && (n <= W);
        chk("ready", ready, !run);
        chk("busy", busy, run);
        chk("done", done, n == W + 1);
        if (!run || n == 0) begin
            chk("result", result, h_res);
            chk("carry_out", carry_out, h_co);
`ifdef OVERFLOW_FLAG_EN
            chk("overflow", overflow, h_ov);
`endif
        end
        if (rst_n) begin
            if (!run && start) begin
                n = 0;
                if (sub) begin
                    m_res = a - b;
                    m_co  = a >= b;
                    m_ov  = (a[W-1] != b[W-1]) && (m_res[W-1] != a[W-1]);
                end else begin
                    t     = {1'b0, a} + {1'b0, b};
                    m_res = t[W-1:0];
                    m_co  = t[W];
                    m_ov  = (a[W-1] == b[W-1]) && (m_res[W-1] != a[W-1]);
                end
                h_res = '0; h_co = 1'b0; h_ov = 1'b0;
            end else if (n >= 0) begin
                n++;
                if (n == W + 1) begin
                    h_res = m_res; h_co = m_co; h_ov = m_ov;
                end else if (n > W + 1) n = -1;
            end
        end
    end

    task automatic run_op(input logic [W-1:0] oa, input logic [W-1:0] ob, input logic os,
                          input logic [W-1:0] er, input logic eco, input logic eov);
        int got = 0;
        @(posedge clk); #1;
        start = 1'b1; a = oa; b = ob; sub = os;
        @(posedge clk); #1;
        start = 1'b0; a = ~oa; b = ~ob; sub = ~os;
        for (int i = 1; i <= 20 && got == 0; i++) begin
            @(posedge clk); #1;
            if (done) got = i;
        end
        chk("latency", got, W + 1);
        chk("lit_result", result, er);
        chk("lit_carry", carry_out, eco);
`ifdef OVERFLOW_FLAG_EN
        chk("lit_overflow", overflow, eov);
`endif
    endtask

    initial begin
        int dn;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        run_op(8'h0F, 8'h01, 1'b0, 8'h10, 1'b0, 1'b0);
        run_op(8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0);
        run_op(8'h07, 8'h05, 1'b1, 8'h02, 1'b1, 1'b0);
        run_op(8'h05, 8'h07, 1'b1, 8'hFE, 1'b0, 1'b0);
        run_op(8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1);
        run_op(8'h80, 8'h01, 1'b1, 8'h7F, 1'b1, 1'b1);
        // start pulsed again mid-run must be ignored
        @(posedge clk); #1;
        start = 1'b1; a = 8'h11; b = 8'h22; sub = 1'b0;
        @(posedge clk); #1 start = 1'b0;
        repeat (3) @(posedge clk);
        #1 start = 1'b1; a = 8'hFF;
        @(posedge clk); #1 start = 1'b0;
        dn = 0;
        for (int i = 0; i < 15; i++) begin
            @(posedge clk); #1;
            if (done) begin
                dn++;
                chk("mid_start_result", result, 8'h33);
            end
        end
        chk("mid_start_dones", dn, 1);
        // reset during RUN aborts without a done pulse
        @(posedge clk); #1;
        start = 1'b1; a = 8'h55; b = 8'h22; sub = 1'b0;
        @(posedge clk); #1 start = 1'b0;
        repeat (4) @(posedge clk);
        #1 rst_n = 1'b0;
        @(negedge clk);
        chk("rst_busy", busy, 1'b0);
        chk("rst_ready", ready, 1'b1);
        chk("rst_result", result, 8'h00);
        @(posedge clk); #1 rst_n = 1'b1;
        dn = 0;
        for (int i = 0; i < 12; i++) begin
            @(posedge clk); #1;
            if (done) dn++;
        end
        chk("rst_no_done", dn, 0);
        run_op(8'h01, 8'h01, 1'b0, 8'h02, 1'b0, 1'b0);
        // start held high: back-to-back accept from DONE
        @(posedge clk); #1;
        start = 1'b1; a = 8'h10; b = 8'h20; sub = 1'b0;
        dn = 0;
        for (int i = 0; i < 40 && dn < 2; i++) begin
            @(posedge clk); #1;
            if (done) begin
                dn++;
                if (dn == 1) begin
                    chk("b2b_result1", result, 8'h30);
                    chk("b2b_carry1", carry_out, 1'b0);
                    a = 8'h03; b = 8'h01; sub = 1'b1;
                end else begin
                    chk("b2b_result2", result, 8'h02);
                    chk("b2b_carry2", carry_out, 1'b1);
                    start = 1'b0;
                end
            end
        end
        chk("b2b_dones", dn, 2);
        start = 1'b0;
        // randomized traffic, corner-biased operands, occasional reset
        repeat (3000) begin
            @(posedge clk); #1;
            rst_n = $urandom_range(0, 199) != 0;
            start = $urandom_range(0, 2) == 0;
            sub   = $urandom_range(0, 1);
            case ($urandom_range(0, 5))
                0: a = 8'h7F;
                1: a = 8'h80;
                default: a = W'($urandom);
            endcase
            case ($urandom_range(0, 5))
                0: b = 8'hFF;
                1: b = 8'h00;
                default: b = W'($urandom);
            endcase
        end
        @(posedge clk); #1;
        rst_n = 1'b1; start = 1'b0;
        repeat (14) @(posedge clk);
        @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
